// File: rtl/bus_arb_pkg.sv
// Shared types and width helpers for the HOLD/HLDA bus arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package bus_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD_REQ = 3'd1,
        ST_GRANT    = 3'd2,
        ST_HANDOFF  = 3'd3,
        ST_RELEASE  = 3'd4
    } arb_state_e;

    // Width of a requester index. Never returns zero, so a 1-entry
    // configuration still gets a legal vector.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Tenure counter width: must hold values 0..max_t inclusive.
    function automatic int cnt_w(input int max_t);
        return (max_t > 0) ? $clog2(max_t + 1) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; vld_o low when no request is set.
//   req_i  : request vector
//   last_i : index of the previous winner (lowest priority this round)
//   vld_o  : some request is set
//   idx_o  : winning index, valid when vld_o
module rr_pick
    import bus_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IW      = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               vld_o,
    output logic [IW-1:0]      idx_o
);

    // Walk from the farthest candidate (last itself) to the nearest
    // (last+1); later hits overwrite earlier ones, so last+1 ends up with
    // the highest priority and the previous winner with the lowest.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req_i[IW'((int'(last_i) + k) % NUM_REQ)]) begin
                vld_o = 1'b1;
                idx_o = IW'((int'(last_i) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/hold_bus_arbiter.sv
// Round-robin sharing of the 8088 bus among NUM_REQ masters via HOLD/HLDA.
// Latency: outputs are registered off the state register (one cycle behind state).
// Backpressure: grants wait for HLDA; owners keep the bus until they drop REQ (PREEMPT is advisory).
//   clk_i, rst_n_i : system clock, asynchronous active-low reset
//   req_i / hlda_i : level requests, CPU hold acknowledge
//   hold_o, gnt_o, owner_o, preempt_o, busy_o, err_o : registered status and grant outputs
module hold_bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int MAX_TENURE = 64,
    localparam int IW         = idx_w(NUM_REQ)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               hlda_i,
    output logic               hold_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IW-1:0]      owner_o,
    output logic               preempt_o,
    output logic               busy_o,
    output logic               err_o
);

    localparam int            CW      = cnt_w(MAX_TENURE);
    localparam logic [CW-1:0] TEN_MAX = CW'(MAX_TENURE);

    arb_state_e         state_q, state_d;
    logic [IW-1:0]      cur_q, cur_d;      // owner as seen by the FSM
    logic [IW-1:0]      last_q, last_d;    // round-robin pointer
    logic [CW-1:0]      ten_q, ten_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic               preempt_q, preempt_d;
    logic               busy_q, busy_d;

    logic               pick_vld;
    logic [IW-1:0]      pick_idx;
    logic [NUM_REQ-1:0] cur_oh;
    logic               others;

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req_i  (req_i),
        .last_i (last_q),
        .vld_o  (pick_vld),
        .idx_o  (pick_idx)
    );

    assign cur_oh = NUM_REQ'(1) << cur_q;
    assign others = |(req_i & ~cur_oh);

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        ten_d   = ten_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if ((|req_i) && !hlda_i) state_d = ST_HOLD_REQ;
            end
            ST_HOLD_REQ: begin
                if (hlda_i) begin
                    if (pick_vld) begin
                        state_d = ST_GRANT;
                        cur_d   = pick_idx;
                        last_d  = pick_idx;
                        ten_d   = '0;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end
            end
            ST_GRANT: begin
                if (!hlda_i) begin
                    // CPU took the bus back under an active grant.
                    err_d   = 1'b1;
                    state_d = ST_RELEASE;
                end else if (!req_i[cur_q]) begin
                    state_d = others ? ST_HANDOFF : ST_RELEASE;
                end else if (ten_q != TEN_MAX) begin
                    ten_d = ten_q + CW'(1);
                end
            end
            ST_HANDOFF: begin
                if (pick_vld) begin
                    state_d = ST_GRANT;
                    cur_d   = pick_idx;
                    last_d  = pick_idx;
                    ten_d   = '0;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!hlda_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode, registered below. GNT is additionally gated by the
    // live HLDA so a lost acknowledge removes the grant on the next edge.
    always_comb begin
        hold_d    = (state_q == ST_HOLD_REQ) || (state_q == ST_GRANT) ||
                    (state_q == ST_HANDOFF);
        gnt_d     = ((state_q == ST_GRANT) && hlda_i) ? cur_oh : '0;
        // PREEMPT latches once tenure is used up and stays until GNT drops.
        preempt_d = (MAX_TENURE > 0) && (state_q == ST_GRANT) && hlda_i &&
                    (preempt_q || ((ten_q == TEN_MAX) && others));
        busy_d    = (state_q != ST_IDLE);
        owner_d   = cur_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            cur_q     <= '0;
            last_q    <= IW'(NUM_REQ - 1);
            ten_q     <= '0;
            err_q     <= 1'b0;
            hold_q    <= 1'b0;
            gnt_q     <= '0;
            owner_q   <= '0;
            preempt_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            last_q    <= last_d;
            ten_q     <= ten_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            preempt_q <= preempt_d;
            busy_q    <= busy_d;
        end
    end

    assign hold_o    = hold_q;
    assign gnt_o     = gnt_q;
    assign owner_o   = owner_q;
    assign preempt_o = preempt_q;
    assign busy_o    = busy_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_hold_bus_arbiter.sv
// Self-checking bench for hold_bus_arbiter (NUM_REQ=4, MAX_TENURE=8).
// Expectations are queued when stimulus is driven and compared after the next edge.
// Grant order is checked against a queue of expected owners.
module tb_hold_bus_arbiter;

    localparam int N = 4;

    localparam logic [2:0] S_HOLD  = 3'd0;
    localparam logic [2:0] S_GNT   = 3'd1;
    localparam logic [2:0] S_OWNER = 3'd2;
    localparam logic [2:0] S_PRE   = 3'd3;
    localparam logic [2:0] S_BUSY  = 3'd4;
    localparam logic [2:0] S_ERR   = 3'd5;

    typedef struct packed {
        logic [2:0]  sel;
        logic [31:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic         hlda = 1'b0;
    logic         hold;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         preempt;
    logic         busy;
    logic         err;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];
    int   order_q[$];
    logic hold_must = 1'b0;

    hold_bus_arbiter #(.NUM_REQ(N), .MAX_TENURE(8)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .hlda_i    (hlda),
        .hold_o    (hold),
        .gnt_o     (gnt),
        .owner_o   (owner),
        .preempt_o (preempt),
        .busy_o    (busy),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic string name_of(input logic [2:0] sel);
        case (sel)
            S_HOLD:  return "hold";
            S_GNT:   return "gnt";
            S_OWNER: return "owner";
            S_PRE:   return "preempt";
            S_BUSY:  return "busy";
            default: return "err";
        endcase
    endfunction

    function automatic logic [31:0] obs_of(input logic [2:0] sel);
        case (sel)
            S_HOLD:  return 32'(hold);
            S_GNT:   return 32'(gnt);
            S_OWNER: return 32'(owner);
            S_PRE:   return 32'(preempt);
            S_BUSY:  return 32'(busy);
            default: return 32'(err);
        endcase
    endfunction

    task automatic expect_o(input logic [2:0] sel, input int val);
        exp_t e;
        e.sel = sel;
        e.val = 32'(val);
        exp_q.push_back(e);
    endtask

    // Advance one clock and compare everything queued for this edge.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq(name_of(e.sel), obs_of(e.sel), e.val);
        end
    endtask

    // Tick until a grant becomes visible; n returns the ticks taken.
    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (gnt == '0 && n < 20);
        check_eq("wait_gnt", 32'(gnt != '0), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        hlda  = 1'b0;
        #1;
        expect_o(S_HOLD, 0); expect_o(S_GNT, 0); expect_o(S_OWNER, 0);
        expect_o(S_PRE, 0);  expect_o(S_BUSY, 0); expect_o(S_ERR, 0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Grant invariants, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gnt != '0) begin
                check_eq("gnt_onehot", 32'($onehot(gnt)), 32'd1);
                check_eq("gnt_without_hold", 32'(hold), 32'd1);
            end
            if (hold_must) check_eq("hold_kept", 32'(hold), 32'd1);
        end
    end

    initial begin
        int n;
        int o;

        // 1: single requester, full handshake and release.
        do_reset();
        req = 4'b0001;
        expect_o(S_HOLD, 0); expect_o(S_BUSY, 0); tick();
        expect_o(S_HOLD, 1); expect_o(S_BUSY, 1); expect_o(S_GNT, 0); tick();
        expect_o(S_GNT, 0); tick();
        hlda = 1'b1;
        expect_o(S_GNT, 0); tick();
        expect_o(S_GNT, 1); expect_o(S_OWNER, 0); expect_o(S_HOLD, 1); tick();
        tick();
        req = 4'b0000;
        expect_o(S_GNT, 1); tick();
        expect_o(S_GNT, 0); expect_o(S_HOLD, 0); expect_o(S_BUSY, 1); tick();
        hlda = 1'b0;
        expect_o(S_BUSY, 1); tick();
        expect_o(S_BUSY, 0); expect_o(S_HOLD, 0); tick();

        // 2: all four requesting, rotating ownership with one dead cycle.
        do_reset();
        order_q.push_back(0); order_q.push_back(1); order_q.push_back(2);
        order_q.push_back(3); order_q.push_back(0);
        req = 4'b1111;
        tick();
        tick();
        hlda = 1'b1;
        hold_must = 1'b1;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(n);
            if (g > 0) check_eq("handoff_gap", 32'(n), 32'd2);
            check_eq("order_left", 32'(order_q.size() > 0), 32'd1);
            if (order_q.size() > 0) check_eq("grant_order", 32'(owner), 32'(order_q.pop_front()));
            o = int'(owner);
            repeat (4) tick();
            req[o] = 1'b0;
            tick();
            if (g < 4) req[o] = 1'b1;
        end
        hold_must = 1'b0;
        check_eq("order_done", 32'(order_q.size()), 32'd0);
        req = 4'b0000;
        tick();
        hlda = 1'b0;
        tick();
        tick();

        // 3: preemption after 8 grant cycles, then handoff to requester 1.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        hlda = 1'b1;
        wait_gnt(n);
        check_eq("pre_owner", 32'(owner), 32'd2);
        req = 4'b0110;
        repeat (7) begin
            expect_o(S_PRE, 0); expect_o(S_GNT, 4); tick();
        end
        expect_o(S_PRE, 1); tick();
        expect_o(S_PRE, 1); tick();
        req = 4'b0010;
        expect_o(S_GNT, 4); expect_o(S_PRE, 1); tick();
        expect_o(S_GNT, 0); expect_o(S_PRE, 0); expect_o(S_HOLD, 1); tick();
        expect_o(S_GNT, 2); expect_o(S_OWNER, 1); expect_o(S_PRE, 0); tick();

        // 4: HLDA lost mid-grant sets sticky ERR.
        do_reset();
        req = 4'b0001;
        tick();
        tick();
        hlda = 1'b1;
        wait_gnt(n);
        tick();
        tick();
        hlda = 1'b0;
        expect_o(S_GNT, 0); expect_o(S_ERR, 1); expect_o(S_HOLD, 1); tick();
        expect_o(S_HOLD, 0); expect_o(S_ERR, 1); expect_o(S_GNT, 0); tick();
        expect_o(S_HOLD, 0); tick();
        expect_o(S_HOLD, 1); expect_o(S_ERR, 1); tick();
        hlda = 1'b1;
        wait_gnt(n);
        check_eq("regrant_gnt", 32'(gnt), 32'd1);
        check_eq("regrant_err", 32'(err), 32'd1);
        req = 4'b0000;
        tick();
        tick();
        hlda = 1'b0;
        tick();
        expect_o(S_ERR, 1); expect_o(S_BUSY, 0); tick();

        // 5: request withdrawn before HLDA arrives.
        do_reset();
        req = 4'b0001;
        tick();
        expect_o(S_HOLD, 1); expect_o(S_BUSY, 1); tick();
        req = 4'b0000;
        expect_o(S_GNT, 0); tick();
        hlda = 1'b1;
        expect_o(S_HOLD, 1); expect_o(S_GNT, 0); tick();
        expect_o(S_HOLD, 0); expect_o(S_GNT, 0); expect_o(S_BUSY, 1); tick();
        hlda = 1'b0;
        expect_o(S_BUSY, 1); expect_o(S_GNT, 0); tick();
        expect_o(S_BUSY, 0); expect_o(S_HOLD, 0); tick();

        // 6: asynchronous reset mid-grant, pointer back to NUM_REQ-1.
        do_reset();
        req = 4'b0100;
        tick();
        tick();
        hlda = 1'b1;
        wait_gnt(n);
        req = 4'b0110;
        repeat (10) tick();
        check_eq("pre_before_rst", 32'(preempt), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rst_hold", 32'(hold), 32'd0);
        check_eq("rst_gnt", 32'(gnt), 32'd0);
        check_eq("rst_pre", 32'(preempt), 32'd0);
        req  = 4'b0000;
        hlda = 1'b0;
        tick();
        rst_n = 1'b1;
        req = 4'b1010;
        tick();
        tick();
        hlda = 1'b1;
        wait_gnt(n);
        check_eq("post_rst_owner", 32'(owner), 32'd1);
        check_eq("post_rst_gnt", 32'(gnt), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
